// File: rtl/lvds_fifo_pkg.sv
// -----------------------------------------------------------------------------
// lvds_fifo_pkg
// Shared definitions for the LVDS receive FIFO controller that fronts a
// 32x512 two-port SRAM.
//   DEF_DW        : default data width (SRAM word width)
//   DEF_AW        : default SRAM address width
//   DEF_DEPTH     : default SRAM depth, 2**DEF_AW
//   DEF_AFULL_LVL : default almost-full threshold on the SRAM word count
//   buf_cnt_t     : occupancy type of the 2-entry output skid buffer
// -----------------------------------------------------------------------------
package lvds_fifo_pkg;

   localparam int DEF_DW        = 32;
   localparam int DEF_AW        = 9;
   localparam int DEF_DEPTH     = 1 << DEF_AW;
   localparam int DEF_AFULL_LVL = 480;

   // Output skid buffer holds 0, 1 or 2 words.
   typedef logic [1:0] buf_cnt_t;
   localparam buf_cnt_t BUF_DEPTH = 2'd2;

endpackage : lvds_fifo_pkg

// File: rtl/lvds_fifo_outbuf.sv
// -----------------------------------------------------------------------------
// lvds_fifo_outbuf
// Two-entry output skid buffer placed after the SRAM read port. The head
// register drives out_data directly, so out_data keeps the last word shown
// when the buffer empties.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : word returning from the SRAM this cycle
//   pop              : consumer takes the head word (ignored when empty)
//   out_valid        : buffer holds at least one word
//   out_data         : head word
//   cnt              : current occupancy (0..2)
// -----------------------------------------------------------------------------
module lvds_fifo_outbuf
   import lvds_fifo_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output buf_cnt_t      cnt
);

   logic [DW-1:0] head_q;
   logic [DW-1:0] skid_q;
   buf_cnt_t      cnt_q;
   logic          pop_ok;
   logic          push_ok;

   assign pop_ok  = pop && (cnt_q != 2'd0);
   // The read scheduler never over-fills the buffer; a push into a full
   // buffer is only accepted when the head leaves in the same cycle.
   assign push_ok = push && ((cnt_q != BUF_DEPTH) || pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         skid_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (push_ok) head_q <= push_data;
            end
            2'd1: begin
               // Head leaves and a new word arrives: new word becomes head.
               if (push_ok && pop_ok) head_q <= push_data;
               else if (push_ok)      skid_q <= push_data;
            end
            2'd2: begin
               if (pop_ok)  head_q <= skid_q;
               if (push_ok) skid_q <= push_data;
            end
            default: ;
         endcase
         cnt_q <= cnt_q + buf_cnt_t'(push_ok) - buf_cnt_t'(pop_ok);
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_q;
   assign cnt       = cnt_q;

endmodule : lvds_fifo_outbuf

// File: rtl/lvds_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// lvds_sram_fifo_ctrl
// FIFO controller around an external 32x512 two-port SRAM (one clock drives
// both SRAM ports). Input words are written straight into the SRAM; reads are
// issued ahead into a 2-entry skid buffer so the output sustains one word per
// cycle despite the one-cycle SRAM read latency.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready, data is only meaningful with valid.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid, in_ready, in_data  : input stream
//   out_valid, out_ready, out_data : output stream
//   wd, waddr, wen               : SRAM write port
//   raddr, rd                    : SRAM read port (rd valid one cycle later)
//   level                        : words held in SRAM (0..2**AW)
//   afull                        : level >= AFULL_LVL
//   drop_cnt                     : dropped-word count (SRAM_FIFO_DROP_EN only)
//
// Build option SRAM_FIFO_DROP_EN: the input cannot be stalled; in_ready stays
// high outside reset and words arriving while the SRAM is full are dropped
// and counted in drop_cnt (saturating).
// -----------------------------------------------------------------------------
module lvds_sram_fifo_ctrl
   import lvds_fifo_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = DEF_AW,
   parameter int AFULL_LVL = DEF_AFULL_LVL
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [DW-1:0] wd,
   output logic [AW-1:0] waddr,
   output logic          wen,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rd,
   output logic [AW:0]   level,
   output logic          afull
`ifdef SRAM_FIFO_DROP_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   localparam int          DEPTH     = 1 << AW;
   localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_LVL);
   localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic          in_flight;
   buf_cnt_t      buf_cnt;
   logic          full;
   logic          empty;
   logic          wr_fire;
   logic          rd_fire;
   logic          pop;
   logic [2:0]    slots_used;

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);

`ifdef SRAM_FIFO_DROP_EN
   assign in_ready = !rst;
`else
   assign in_ready = !full && !rst;
`endif

   // Only the SRAM fullness gates the write; in drop mode in_ready is high
   // even when full, and those words are simply not written.
   assign wr_fire = in_valid && !full && !rst;

   assign pop = out_valid && out_ready;

   // Output-side slots committed after this cycle: words buffered, plus the
   // word returning from the SRAM, minus the word leaving. Counting the pop
   // lets a new read issue every cycle while the consumer keeps up.
   assign slots_used = {1'b0, buf_cnt} + {2'b00, in_flight} - {2'b00, pop};

   // level counts only words committed at earlier edges, so a read can never
   // target the address being written in the same cycle.
   assign rd_fire = !empty && !rst && (slots_used < 3'd2);

   assign wen   = wr_fire;
   assign waddr = wr_ptr;
   assign wd    = in_data;
   assign raddr = rd_ptr;
   assign level = level_q;
   assign afull = (level_q >= LVL_AFULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         in_flight <= 1'b0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
         in_flight <= rd_fire;
         case ({wr_fire, rd_fire})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: ;
         endcase
      end
   end

`ifdef SRAM_FIFO_DROP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (in_valid && full && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

   // A word returning during the reset cycle is discarded by the buffer's
   // own reset, which has priority over push.
   lvds_fifo_outbuf #(
      .DW (DW)
   ) u_outbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (in_flight),
      .push_data (rd),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .cnt       (buf_cnt)
   );

endmodule : lvds_sram_fifo_ctrl

// File: tb/tb_lvds_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lvds_sram_fifo_ctrl
// Self-checking bench for lvds_sram_fifo_ctrl with a behavioural SRAM and a
// queue reference model of the FIFO contents.
// -----------------------------------------------------------------------------
module tb_lvds_sram_fifo_ctrl;

   localparam int DW        = 32;
   localparam int AW        = 9;
   localparam int DEPTH     = 512;
   localparam int AFULL_LVL = 480;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [DW-1:0] wd;
   logic [AW-1:0] waddr;
   logic          wen;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rd;
   logic [AW:0]   level;
   logic          afull;
`ifdef SRAM_FIFO_DROP_EN
   logic [15:0]   drop_cnt;
`endif

   lvds_sram_fifo_ctrl #(
      .DW        (DW),
      .AW        (AW),
      .AFULL_LVL (AFULL_LVL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .wd        (wd),
      .waddr     (waddr),
      .wen       (wen),
      .raddr     (raddr),
      .rd        (rd),
      .level     (level),
      .afull     (afull)
`ifdef SRAM_FIFO_DROP_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   // ---------------- behavioural two-port SRAM ----------------
   logic [DW-1:0] sram [DEPTH];
   always @(posedge clk) begin
      if (wen) sram[waddr] <= wd;
      rd <= sram[raddr];
   end

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_waddr = '0;
   logic [DW-1:0] last_out  = '0;
   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;
   int n_pop    = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // One cycle: drive at the falling edge, settle, score, cross the rising
   // edge and return at the next falling edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
      logic acc;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
`ifdef SRAM_FIFO_DROP_EN
      check("in_ready_push_only", in_ready, 1);
      acc = v && (level != 10'd512);
`else
      acc = v && in_ready;
`endif
      check("wen", wen, acc);
      if (acc) begin
         check("waddr", waddr, exp_waddr);
         check("wd", wd, d);
         exp_q.push_back(d);
         exp_waddr = exp_waddr + 9'd1;
         n_acc++;
      end
      if (out_valid && r) begin
         if (exp_q.size() == 0) check("unexpected_out", 1, 0);
         else check("out_data", out_data, exp_q.pop_front());
         last_out = out_data;
         n_pop++;
      end
      check("afull", afull, (level >= 10'(AFULL_LVL)));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         step(1'b0, '0, 1'b1);
         k++;
      end
      check("drain_left", exp_q.size(), 0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      check("drain_level", level, 0);
      check("drain_out_valid", out_valid, 0);
      check("drain_out_hold", out_data, last_out);
   endtask

   task automatic pulse_reset(input int cycles);
      rst      = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_wen", wen, 0);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("rst_level", level, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_afull", afull, 0);
`ifdef SRAM_FIFO_DROP_EN
      check("rst_drop_cnt", drop_cnt, 0);
`endif
      rst = 1'b0;
      exp_q.delete();
      exp_waddr = '0;
      #1;
      check("in_ready_after_rst", in_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bubbles;
      bit seen;
      @(negedge clk);
      pulse_reset(2);

      // Single word latency: write at edge 0, visible after edge 2.
      step(1'b1, 32'hA5A5A5A5, 1'b1);
      check("lat_level_e0", level, 1);
      check("lat_valid_e0", out_valid, 0);
      step(1'b0, '0, 1'b1);
      check("lat_level_e1", level, 0);
      check("lat_valid_e1", out_valid, 0);
      step(1'b0, '0, 1'b1);
      check("lat_valid_e2", out_valid, 1);
      check("lat_data_e2", out_data, 32'hA5A5A5A5);
      step(1'b0, '0, 1'b1);
      check("lat_empty_valid", out_valid, 0);
      check("lat_empty_hold", out_data, 32'hA5A5A5A5);

      // Fill: SRAM holds 512 plus 2 in the skid buffer.
      base = n_acc;
      for (int i = 0; i < 514; i++) step(1'b1, 32'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
      check("fill_accepted", n_acc - base, 514);
      check("fill_level", level, 512);
      check("fill_afull", afull, 1);
`ifndef SRAM_FIFO_DROP_EN
      check("fill_in_ready", in_ready, 0);
`endif
      for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD0000 + 32'(i), 1'b0);
      check("full_extra_level", level, 512);
`ifdef SRAM_FIFO_DROP_EN
      check("drop_cnt_3", drop_cnt, 3);
`endif

      // Full with random consumer and a permanently valid producer.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, $urandom, 1'($urandom_range(0, 1)));
         check("full_level_min", (level >= 10'd511), 1);
      end
      drain(1200);

      // Continuous stream with wrap, no output bubbles once primed.
      base    = n_pop;
      bubbles = 0;
      seen    = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         step(1'b1, 32'(i), 1'b1);
         if (out_valid) seen = 1'b1;
         else if (seen && (n_pop - base) < 1200) bubbles++;
      end
      for (int k = 0; k < 10 && (n_pop - base) < 1200; k++) begin
         step(1'b0, '0, 1'b1);
         if (!out_valid && (n_pop - base) < 1200) bubbles++;
      end
      check("stream_popped", n_pop - base, 1200);
      check("stream_bubbles", bubbles, 0);
      drain(20);

      // Reset while holding 100 words in SRAM.
      for (int i = 0; i < 102; i++) step(1'b1, $urandom, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
      check("pre_rst_level", level, 100);
      pulse_reset(1);
      step(1'b1, 32'hCAFEF00D, 1'b1);
      drain(20);
      check("post_rst_last", last_out, 32'hCAFEF00D);

      // Random traffic, producer-heavy then consumer-heavy.
      for (int i = 0; i < 1200; i++)
         step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0));
      for (int i = 0; i < 1200; i++)
         step(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
      drain(1200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_lvds_sram_fifo_ctrl
